pe_mac_acc: RTL and testbench

- Parametrised successor to the 8-bit systolic processing element, intended as the tile of the next-generation systolic array.
- Generic data and accumulator widths; signed or unsigned arithmetic; optional saturation.
- Valid-qualified operand forwarding (right/down); sticky overflow flag.
- Mode input selects hold, multiply-accumulate, column drain (accumulator shift-down chain) or clear.
- Array controller drives mode to all PEs of a column; results exit the bottom row during drain.

---
 rtl/pe_mac_acc_if.sv | 32 +++
 rtl/pe_mac_acc.sv | 143 ++++++++++++++
 tb/tb_pe_mac_acc.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_mac_acc_if.sv
// Port bundle of one systolic processing element: operand inputs from the
// PE above and to the left, the mode and drain-chain input, and the
// forwarded operands plus accumulator/overflow results.
interface pe_mac_acc_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
);
  logic [1:0]        mode;
  logic [DATA_W-1:0] top_in;
  logic              top_vld;
  logic [DATA_W-1:0] left_in;
  logic              left_vld;
  logic [ACC_W-1:0]  acc_in;
  logic [DATA_W-1:0] down_out;
  logic              down_vld;
  logic [DATA_W-1:0] right_out;
  logic              right_vld;
  logic [ACC_W-1:0]  acc_out;
  logic              ovf;

  // Array controller / neighbouring PEs drive the inputs.
  modport master (
    output mode, top_in, top_vld, left_in, left_vld, acc_in,
    input  down_out, down_vld, right_out, right_vld, acc_out, ovf
  );

  // The processing element itself.
  modport slave (
    input  mode, top_in, top_vld, left_in, left_vld, acc_in,
    output down_out, down_vld, right_out, right_vld, acc_out, ovf
  );
endinterface

// File: rtl/pe_mac_acc.sv
// Parametrised systolic processing element: forwards its operands right and
// down with one cycle of latency, multiply-accumulates valid operand pairs
// into a signed or unsigned accumulator with optional saturation, keeps a
// sticky overflow flag, and acts as one stage of a column drain shift chain.
module pe_mac_acc #(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 24,    // must be >= 2*DATA_W
  parameter bit SIGNED   = 1'b1,  // 1: two's complement, 0: unsigned
  parameter bit SATURATE = 1'b1   // 1: clamp on overflow, 0: wrap
) (
  input  logic          clk,
  input  logic          reset,   // asynchronous, active low
  pe_mac_acc_if.slave   bus
);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_MAC   = 2'b01,
    MODE_DRAIN = 2'b10,
    MODE_CLEAR = 2'b11
  } mode_e;

  localparam int PROD_W = 2 * DATA_W;

  // Representable accumulator range, used as saturation targets.
  localparam logic [ACC_W-1:0] ACC_MAX = SIGNED ? {1'b0, {(ACC_W-1){1'b1}}} : {ACC_W{1'b1}};
  localparam logic [ACC_W-1:0] ACC_MIN = SIGNED ? {1'b1, {(ACC_W-1){1'b0}}} : {ACC_W{1'b0}};

  // State
  logic [ACC_W-1:0]  r_acc;
  logic              r_ovf;
  logic [DATA_W-1:0] r_down;
  logic              r_down_vld;
  logic [DATA_W-1:0] r_right;
  logic              r_right_vld;

  // Datapath
  mode_e             w_mode;
  logic              w_fire;
  logic [PROD_W-1:0] w_top_x;
  logic [PROD_W-1:0] w_left_x;
  logic [PROD_W-1:0] w_prod;
  logic [ACC_W:0]    w_prod_x;
  logic [ACC_W:0]    w_acc_x;
  logic [ACC_W:0]    w_sum;
  logic              w_ovf_add;
  logic              w_ovf_neg;
  logic [ACC_W-1:0]  w_mac_res;
  logic [ACC_W-1:0]  w_acc_nxt;
  logic              w_ovf_nxt;

  assign w_mode = mode_e'(bus.mode);
  assign w_fire = bus.top_vld & bus.left_vld;

  // Operands are widened to the product width first; the low 2*DATA_W bits
  // of the product are then correct for both signed and unsigned operands.
  assign w_top_x  = {{DATA_W{SIGNED & bus.top_in[DATA_W-1]}},  bus.top_in};
  assign w_left_x = {{DATA_W{SIGNED & bus.left_in[DATA_W-1]}}, bus.left_in};
  assign w_prod   = w_top_x * w_left_x;

  // One guard bit above the accumulator so overflow can be detected exactly.
  assign w_prod_x = {{(ACC_W + 1 - PROD_W){SIGNED & w_prod[PROD_W-1]}}, w_prod};
  assign w_acc_x  = {SIGNED & r_acc[ACC_W-1], r_acc};
  assign w_sum    = w_acc_x + w_prod_x;

  // Signed: the guard bit disagrees with the result sign bit when the true
  // sum left the range; the guard bit then gives the true sign (direction).
  // Unsigned: the guard bit is the carry out, always an upward overflow.
  assign w_ovf_add = SIGNED ? (w_sum[ACC_W] ^ w_sum[ACC_W-1]) : w_sum[ACC_W];
  assign w_ovf_neg = SIGNED & w_sum[ACC_W];

  // MAC result: truncated sum, or the bound in the overflow direction.
  assign w_mac_res = (w_ovf_add && SATURATE) ? (w_ovf_neg ? ACC_MIN : ACC_MAX)
                                             : w_sum[ACC_W-1:0];

  // Next accumulator/overflow value selected by the sampled mode.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // that no path leaves it unassigned, which would infer a latch.
    w_acc_nxt = r_acc;
    w_ovf_nxt = r_ovf;
    case (w_mode)
      MODE_HOLD: begin
        w_acc_nxt = r_acc;
        w_ovf_nxt = r_ovf;
      end
      MODE_MAC: begin
        if (w_fire) begin
          w_acc_nxt = w_mac_res;
          w_ovf_nxt = r_ovf | w_ovf_add;
        end
      end
      MODE_DRAIN: begin
        w_acc_nxt = bus.acc_in;
      end
      MODE_CLEAR: begin
        w_acc_nxt = '0;
        w_ovf_nxt = 1'b0;
      end
      default: begin
        w_acc_nxt = r_acc;
        w_ovf_nxt = r_ovf;
      end
    endcase
  end

  // Accumulator and sticky overflow register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of block ordering.
    if (!reset) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_acc <= w_acc_nxt;
      r_ovf <= w_ovf_nxt;
    end
  end

  // Operand forwarding: data registers follow the inputs every cycle; the
  // valid bits carry the qualification.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_down      <= '0;
      r_down_vld  <= 1'b0;
      r_right     <= '0;
      r_right_vld <= 1'b0;
    end else begin
      r_down      <= bus.top_in;
      r_down_vld  <= bus.top_vld;
      r_right     <= bus.left_in;
      r_right_vld <= bus.left_vld;
    end
  end

  assign bus.acc_out   = r_acc;
  assign bus.ovf       = r_ovf;
  assign bus.down_out  = r_down;
  assign bus.down_vld  = r_down_vld;
  assign bus.right_out = r_right;
  assign bus.right_vld = r_right_vld;

endmodule

// File: tb/tb_pe_mac_acc.sv
// Testbench for pe_mac_acc: four single PEs with different parameter sets
// share one stimulus stream (24-bit signed saturating, 16-bit signed
// saturating, 16-bit signed wrapping, 16-bit unsigned saturating), plus a
// four-PE drain column. Directed vectors come from a table, multi-cycle
// corners are hand sequenced, and a random phase is scored against an
// integer-arithmetic reference model.
module tb_pe_mac_acc;

  localparam logic [1:0] M_HOLD  = 2'b00;
  localparam logic [1:0] M_MAC   = 2'b01;
  localparam logic [1:0] M_DRAIN = 2'b10;
  localparam logic [1:0] M_CLEAR = 2'b11;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Shared stimulus for the single PEs
  logic [1:0]  d_mode;
  logic [7:0]  d_top;
  logic        d_tv;
  logic [7:0]  d_left;
  logic        d_lv;
  logic [23:0] d_ain;

  // Column stimulus and observation
  logic [1:0]  c_mode;
  logic [7:0]  c_top [4];
  logic        c_tv;
  logic [7:0]  c_left;
  logic        c_lv;
  logic [23:0] c_acc [4];
  logic [18:0] c_fwd [4];

  pe_mac_acc_if #(.DATA_W(8), .ACC_W(24)) if_a ();
  pe_mac_acc_if #(.DATA_W(8), .ACC_W(16)) if_s ();
  pe_mac_acc_if #(.DATA_W(8), .ACC_W(16)) if_w ();
  pe_mac_acc_if #(.DATA_W(8), .ACC_W(16)) if_u ();

  assign if_a.mode = d_mode;  assign if_a.top_in = d_top;  assign if_a.top_vld = d_tv;
  assign if_a.left_in = d_left; assign if_a.left_vld = d_lv; assign if_a.acc_in = d_ain;
  assign if_s.mode = d_mode;  assign if_s.top_in = d_top;  assign if_s.top_vld = d_tv;
  assign if_s.left_in = d_left; assign if_s.left_vld = d_lv; assign if_s.acc_in = d_ain[15:0];
  assign if_w.mode = d_mode;  assign if_w.top_in = d_top;  assign if_w.top_vld = d_tv;
  assign if_w.left_in = d_left; assign if_w.left_vld = d_lv; assign if_w.acc_in = d_ain[15:0];
  assign if_u.mode = d_mode;  assign if_u.top_in = d_top;  assign if_u.top_vld = d_tv;
  assign if_u.left_in = d_left; assign if_u.left_vld = d_lv; assign if_u.acc_in = d_ain[15:0];

  pe_mac_acc #(.DATA_W(8), .ACC_W(24), .SIGNED(1'b1), .SATURATE(1'b1))
    u_dut_a (.clk(clk), .reset(rst_n), .bus(if_a));
  pe_mac_acc #(.DATA_W(8), .ACC_W(16), .SIGNED(1'b1), .SATURATE(1'b1))
    u_dut_s (.clk(clk), .reset(rst_n), .bus(if_s));
  pe_mac_acc #(.DATA_W(8), .ACC_W(16), .SIGNED(1'b1), .SATURATE(1'b0))
    u_dut_w (.clk(clk), .reset(rst_n), .bus(if_w));
  pe_mac_acc #(.DATA_W(8), .ACC_W(16), .SIGNED(1'b0), .SATURATE(1'b1))
    u_dut_u (.clk(clk), .reset(rst_n), .bus(if_u));

  // Four-PE column, index 0 at the top; drain chain acc_out -> acc_in.
  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    pe_mac_acc_if #(.DATA_W(8), .ACC_W(24)) cif ();
    assign cif.mode     = c_mode;
    assign cif.top_in   = c_top[gi];
    assign cif.top_vld  = c_tv;
    assign cif.left_in  = c_left;
    assign cif.left_vld = c_lv;
    if (gi == 0) begin : g_top
      assign cif.acc_in = 24'd0;
    end else begin : g_chain
      assign cif.acc_in = c_acc[gi-1];
    end
    assign c_acc[gi] = cif.acc_out;
    assign c_fwd[gi] = {cif.ovf, cif.down_vld, cif.down_out, cif.right_vld, cif.right_out};
    pe_mac_acc #(.DATA_W(8), .ACC_W(24), .SIGNED(1'b1), .SATURATE(1'b1))
      u_pe (.clk(clk), .reset(rst_n), .bus(cif));
  end

  // ---------------- reference model ----------------
  typedef struct {
    longint acc;
    bit     ovf;
  } mstate_t;

  int      acc_w [4] = '{24, 16, 16, 16};
  bit      sgn   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  bit      sat   [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  mstate_t m     [4];

  // Reduce any integer to the value a w-bit register would hold.
  function automatic longint norm(longint v, int w, bit sg);
    longint span = longint'(1) << w;
    longint r    = v & (span - 1);
    if (sg && r >= span / 2) r = r - span;
    return r;
  endfunction

  function automatic mstate_t model_step(mstate_t s, int w, bit sg, bit st,
                                         logic [1:0] md, logic [7:0] t, logic tv,
                                         logic [7:0] l, logic lv, longint ain);
    mstate_t n = s;
    longint span = longint'(1) << w;
    longint lo   = sg ? -(span / 2) : 0;
    longint hi   = sg ? (span / 2) - 1 : span - 1;
    longint prod;
    longint sum;
    case (md)
      M_MAC: begin
        if (tv && lv) begin
          prod = sg ? longint'($signed(t)) * longint'($signed(l))
                    : longint'(t) * longint'(l);
          sum  = s.acc + prod;
          if (sum > hi || sum < lo) begin
            n.ovf = 1'b1;
            n.acc = st ? ((sum > hi) ? hi : lo) : norm(sum, w, sg);
          end else begin
            n.acc = sum;
          end
        end
      end
      M_DRAIN: n.acc = ain;
      M_CLEAR: begin
        n.acc = 0;
        n.ovf = 1'b0;
      end
      default: n = s;
    endcase
    return n;
  endfunction

  // ---------------- DUT observation ----------------
  function automatic longint get_acc(int sel);
    case (sel)
      0:       return norm(longint'(if_a.acc_out), 24, 1'b1);
      1:       return norm(longint'(if_s.acc_out), 16, 1'b1);
      2:       return norm(longint'(if_w.acc_out), 16, 1'b1);
      default: return norm(longint'(if_u.acc_out), 16, 1'b0);
    endcase
  endfunction

  function automatic logic get_ovf(int sel);
    case (sel)
      0:       return if_a.ovf;
      1:       return if_s.ovf;
      2:       return if_w.ovf;
      default: return if_u.ovf;
    endcase
  endfunction

  function automatic logic [17:0] get_fwd(int sel);
    case (sel)
      0:       return {if_a.down_vld, if_a.down_out, if_a.right_vld, if_a.right_out};
      1:       return {if_s.down_vld, if_s.down_out, if_s.right_vld, if_s.right_out};
      2:       return {if_w.down_vld, if_w.down_out, if_w.right_vld, if_w.right_out};
      default: return {if_u.down_vld, if_u.down_out, if_u.right_vld, if_u.right_out};
    endcase
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_models();
    for (int s = 0; s < 4; s++) begin
      m[s].acc = 0;
      m[s].ovf = 1'b0;
    end
  endtask

  // Hold reset across an edge, confirm every output is cleared, release.
  task automatic do_reset();
    rst_n  = 1'b0;
    d_mode = M_HOLD;
    c_mode = M_HOLD;
    step();
    #1;
    for (int s = 0; s < 4; s++) begin
      check($sformatf("rst_acc%0d", s), get_acc(s), 0);
      check($sformatf("rst_ovf%0d", s), longint'(get_ovf(s)), 0);
      check($sformatf("rst_fwd%0d", s), longint'(get_fwd(s)), 0);
      check($sformatf("rst_col%0d", s), longint'(c_acc[s]), 0);
    end
    rst_n = 1'b1;
    clear_models();
  endtask

  function automatic logic [7:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return 8'h80;
      1:       return 8'h7F;
      2:       return 8'hFF;
      3:       return 8'h01;
      default: return 8'($urandom());
    endcase
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    int          sel;
    bit          rst;
    logic [1:0]  mode;
    logic [7:0]  t;
    logic        tv;
    logic [7:0]  l;
    logic        lv;
    logic [23:0] ain;
    longint      exp_acc;
    bit          exp_ovf;
  } vec_t;

  function automatic vec_t mk(int sel, bit rst, logic [1:0] md, logic [7:0] t, logic tv,
                              logic [7:0] l, logic lv, logic [23:0] ain,
                              longint ea, bit eo);
    vec_t v;
    v.sel = sel; v.rst = rst; v.mode = md; v.t = t; v.tv = tv;
    v.l = l; v.lv = lv; v.ain = ain; v.exp_acc = ea; v.exp_ovf = eo;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          preload [4] = '{10, 20, 30, 40};
    longint      exp_q[$];

    rst_n  = 1'b0;
    d_mode = M_HOLD; d_top = '0; d_tv = 1'b0; d_left = '0; d_lv = 1'b0; d_ain = '0;
    c_mode = M_HOLD; c_tv = 1'b0; c_left = '0; c_lv = 1'b0;
    for (int i = 0; i < 4; i++) c_top[i] = '0;
    clear_models();

    // 24-bit signed: basic MAC, bubbles, hold, drain load, clear
    vecs.push_back(mk(0, 1'b1, M_MAC,   8'h03, 1'b1, 8'h04, 1'b1, 24'd0, 12, 1'b0));
    vecs.push_back(mk(0, 1'b0, M_MAC,   8'h05, 1'b1, 8'hFE, 1'b1, 24'd0, 2,  1'b0));
    vecs.push_back(mk(0, 1'b0, M_MAC,   8'hF9, 1'b1, 8'hF9, 1'b1, 24'd0, 51, 1'b0));
    vecs.push_back(mk(0, 1'b0, M_MAC,   8'h02, 1'b1, 8'h09, 1'b0, 24'd0, 51, 1'b0));
    vecs.push_back(mk(0, 1'b0, M_MAC,   8'h02, 1'b1, 8'h0A, 1'b0, 24'd0, 51, 1'b0));
    vecs.push_back(mk(0, 1'b0, M_MAC,   8'h02, 1'b1, 8'h0B, 1'b0, 24'd0, 51, 1'b0));
    vecs.push_back(mk(0, 1'b0, M_MAC,   8'h02, 1'b1, 8'h02, 1'b1, 24'd0, 55, 1'b0));
    vecs.push_back(mk(0, 1'b0, M_HOLD,  8'h0A, 1'b1, 8'h0A, 1'b1, 24'd0, 55, 1'b0));
    vecs.push_back(mk(0, 1'b0, M_DRAIN, 8'h00, 1'b0, 8'h00, 1'b0, 24'hFFFFFB, -5, 1'b0));
    vecs.push_back(mk(0, 1'b0, M_CLEAR, 8'h00, 1'b0, 8'h00, 1'b0, 24'd0, 0,  1'b0));
    // 16-bit signed saturating
    vecs.push_back(mk(1, 1'b1, M_MAC,   8'h80, 1'b1, 8'h80, 1'b1, 24'd0, 16384,  1'b0));
    vecs.push_back(mk(1, 1'b0, M_MAC,   8'h80, 1'b1, 8'h80, 1'b1, 24'd0, 32767,  1'b1));
    vecs.push_back(mk(1, 1'b0, M_MAC,   8'hFF, 1'b1, 8'h01, 1'b1, 24'd0, 32766,  1'b1));
    vecs.push_back(mk(1, 1'b0, M_CLEAR, 8'h00, 1'b0, 8'h00, 1'b0, 24'd0, 0,      1'b0));
    vecs.push_back(mk(1, 1'b0, M_MAC,   8'h80, 1'b1, 8'h7F, 1'b1, 24'd0, -16256, 1'b0));
    vecs.push_back(mk(1, 1'b0, M_MAC,   8'h80, 1'b1, 8'h7F, 1'b1, 24'd0, -32512, 1'b0));
    vecs.push_back(mk(1, 1'b0, M_MAC,   8'h80, 1'b1, 8'h7F, 1'b1, 24'd0, -32768, 1'b1));
    vecs.push_back(mk(1, 1'b0, M_MAC,   8'hFF, 1'b1, 8'hFF, 1'b1, 24'd0, -32767, 1'b1));
    // 16-bit signed wrapping
    vecs.push_back(mk(2, 1'b1, M_MAC,   8'h80, 1'b1, 8'h80, 1'b1, 24'd0, 16384,  1'b0));
    vecs.push_back(mk(2, 1'b0, M_MAC,   8'h80, 1'b1, 8'h80, 1'b1, 24'd0, -32768, 1'b1));
    vecs.push_back(mk(2, 1'b0, M_MAC,   8'hFF, 1'b1, 8'h01, 1'b1, 24'd0, 32767,  1'b1));
    vecs.push_back(mk(2, 1'b0, M_CLEAR, 8'h00, 1'b0, 8'h00, 1'b0, 24'd0, 0,      1'b0));
    vecs.push_back(mk(2, 1'b0, M_MAC,   8'h80, 1'b1, 8'h7F, 1'b1, 24'd0, -16256, 1'b0));
    vecs.push_back(mk(2, 1'b0, M_MAC,   8'h80, 1'b1, 8'h7F, 1'b1, 24'd0, -32512, 1'b0));
    vecs.push_back(mk(2, 1'b0, M_MAC,   8'h80, 1'b1, 8'h7F, 1'b1, 24'd0, 16768,  1'b1));
    vecs.push_back(mk(2, 1'b0, M_MAC,   8'hFF, 1'b1, 8'hFF, 1'b1, 24'd0, 16769,  1'b1));
    // 16-bit unsigned saturating: all-ones operands
    vecs.push_back(mk(3, 1'b1, M_MAC,   8'hFF, 1'b1, 8'hFF, 1'b1, 24'd0, 65025, 1'b0));
    vecs.push_back(mk(3, 1'b0, M_MAC,   8'hFF, 1'b1, 8'hFF, 1'b1, 24'd0, 65535, 1'b1));
    vecs.push_back(mk(3, 1'b0, M_HOLD,  8'hFF, 1'b1, 8'hFF, 1'b1, 24'd0, 65535, 1'b1));
    vecs.push_back(mk(3, 1'b0, M_MAC,   8'h00, 1'b1, 8'h05, 1'b1, 24'd0, 65535, 1'b1));
    vecs.push_back(mk(3, 1'b0, M_CLEAR, 8'h00, 1'b0, 8'h00, 1'b0, 24'd0, 0,     1'b0));
    vecs.push_back(mk(3, 1'b0, M_MAC,   8'hFF, 1'b0, 8'hFF, 1'b1, 24'd0, 0,     1'b0));

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      d_mode = vecs[i].mode; d_top = vecs[i].t; d_tv = vecs[i].tv;
      d_left = vecs[i].l;    d_lv  = vecs[i].lv; d_ain = vecs[i].ain;
      step();
      check($sformatf("tbl%0d_dut%0d_acc", i, vecs[i].sel), get_acc(vecs[i].sel), vecs[i].exp_acc);
      check($sformatf("tbl%0d_dut%0d_ovf", i, vecs[i].sel), longint'(get_ovf(vecs[i].sel)),
            longint'(vecs[i].exp_ovf));
      if (vecs[i].sel == 0)
        check($sformatf("tbl%0d_fwd", i), longint'(get_fwd(0)),
              longint'({vecs[i].tv, vecs[i].t, vecs[i].lv, vecs[i].l}));
    end

    // Column: MAC preload followed directly by DRAIN; bottom PE shows the
    // stored values bottom-first, then zeros from the top tie-off.
    do_reset();
    c_mode = M_MAC; c_tv = 1'b1; c_lv = 1'b1; c_left = 8'd1;
    for (int i = 0; i < 4; i++) c_top[i] = 8'(preload[i]);
    step();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("col_pre%0d", i), longint'(c_acc[i]), preload[i]);
      check($sformatf("col_fwd%0d", i), longint'(c_fwd[i]),
            longint'({1'b0, 1'b1, c_top[i], 1'b1, 8'd1}));
    end
    for (int i = 3; i >= 0; i--) exp_q.push_back(preload[i]);
    exp_q.push_back(0);
    c_mode = M_DRAIN; c_tv = 1'b0; c_lv = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("col_drain%0d", k), longint'(c_acc[3]), exp_q[k]);
      if (k < 4) step();
    end
    for (int i = 0; i < 4; i++)
      check($sformatf("col_empty%0d", i), longint'(c_acc[i]), 0);

    // Asynchronous reset between edges in the middle of a drain.
    c_mode = M_MAC; c_tv = 1'b1; c_lv = 1'b1;
    d_mode = M_MAC; d_top = 8'd16; d_tv = 1'b1; d_left = 8'd16; d_lv = 1'b1;
    step();
    check("mid_mac_a", get_acc(0), 256);
    c_mode = M_DRAIN; d_mode = M_DRAIN; d_ain = 24'd777;
    step();
    check("mid_drain_col", longint'(c_acc[3]), 30);
    check("mid_drain_a", get_acc(0), 777);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++)
      check($sformatf("async_col%0d", i), longint'(c_acc[i]), 0);
    check("async_acc_a", get_acc(0), 0);
    check("async_ovf_a", longint'(get_ovf(0)), 0);
    check("async_fwd_a", longint'(get_fwd(0)), 0);
    #1;
    rst_n  = 1'b1;
    c_mode = M_HOLD; c_tv = 1'b0; c_lv = 1'b0;
    d_mode = M_HOLD; d_tv = 1'b0; d_lv = 1'b0;
    step();
    step();
    for (int i = 0; i < 4; i++)
      check($sformatf("post_rst_col%0d", i), longint'(c_acc[i]), 0);
    check("post_rst_a", get_acc(0), 0);
    clear_models();

    // Random phase against the reference model.
    for (int cyc = 0; cyc < 400; cyc++) begin
      int r;
      r      = $urandom_range(0, 99);
      d_mode = (r < 65) ? M_MAC : (r < 80) ? M_HOLD : (r < 95) ? M_DRAIN : M_CLEAR;
      d_top  = rand_op();
      d_left = rand_op();
      d_tv   = ($urandom_range(0, 3) != 0);
      d_lv   = ($urandom_range(0, 3) != 0);
      d_ain  = 24'($urandom());
      for (int s = 0; s < 4; s++)
        m[s] = model_step(m[s], acc_w[s], sgn[s], sat[s], d_mode, d_top, d_tv, d_left, d_lv,
                          norm(longint'(d_ain), acc_w[s], sgn[s]));
      step();
      for (int s = 0; s < 4; s++) begin
        check($sformatf("rnd%0d_dut%0d_acc", cyc, s), get_acc(s), m[s].acc);
        check($sformatf("rnd%0d_dut%0d_ovf", cyc, s), longint'(get_ovf(s)), longint'(m[s].ovf));
        check($sformatf("rnd%0d_dut%0d_fwd", cyc, s), longint'(get_fwd(s)),
              longint'({d_tv, d_top, d_lv, d_left}));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
